pipe_hazard_ctrl: RTL

//  Central sequencer for the 5-stage pipeline buffer registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.

---
 rtl/pipe_hazard_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline register enable/flush sequencer for load-use, branch and dmem-wait hazards
module pipe_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_tkn,
  input  logic             mem_access,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t     state;
  logic [7:0] wait_cnt;
  logic       lu;
  logic       mst;
  logic       freeze;
  logic       run_dec;

  assign lu  = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign mst = mem_access && !dmem_ack;

  always_comb begin
    freeze       = 1'b0;
    run_dec      = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    mem_wb_flush = 1'b0;
    dmem_req     = 1'b0;
    mem_err      = 1'b0;
    if (!reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          dmem_req = mem_access;
          freeze   = mst;
          run_dec  = !mst;
        end
        MEM_WAIT: begin
          dmem_req = 1'b1;
          freeze   = !dmem_ack;
          run_dec  = dmem_ack;
        end
        default: begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
          mem_err   = 1'b1;
        end
      endcase
      // MEM/WB keeps loading during a freeze so the stalled access retires as a bubble
      if (freeze) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_flush = 1'b1;
      end
      // Branch squashes ID, so a load-use on that instruction is moot
      if (run_dec) begin
        if (ex_branch_tkn) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (lu) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mst) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= ERR;
      endcase
      if (!pc_en && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (run_dec && if_id_flush && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule
